// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state encoding and default widths for the mux select sequencer
package mux_scan_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SEEK = 2'd1, SETTLE = 2'd2, DWELL = 2'd3} state_t;
  localparam int SEL_W_DEF = 3;
  localparam int DWELL_W_DEF = 8;
endpackage

// File: rtl/mux_scan_seq_next_en_ch.sv
// next_en_ch: lowest enabled channel at or above base, wrapping modulo 2**SEL_W
module next_en_ch import mux_scan_pkg::*; #(
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [2**SEL_W-1:0] mask,
  input  logic [SEL_W-1:0]    base,
  output logic [SEL_W-1:0]    idx,
  output logic                found,
  output logic                wrapped
);
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = 2**SEL_W - 1; i >= 0; i--)
      if (mask[SEL_W'(base + SEL_W'(i))]) begin
        idx = SEL_W'(base + SEL_W'(i));
        found = 1'b1;
      end
    wrapped = found && (idx < base);
  end
endmodule

// File: rtl/mux_scan_seq.sv
// mux_scan_seq: scans enabled channels driving mux2_1 select lines; MUX_SCAN_SETTLE_EN adds a blanking cycle
module mux_scan_seq import mux_scan_pkg::*; #(
  parameter int SEL_W = SEL_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [2**SEL_W-1:0] ch_en,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [SEL_W-1:0]    a,
  output logic                sel_valid,
  output logic                sample,
  output logic                frame_done,
  output logic                busy
);
  localparam int N = 2**SEL_W;
`ifdef MUX_SCAN_SETTLE_EN
  localparam state_t AFTER_SEEK = SETTLE;
`else
  localparam state_t AFTER_SEEK = DWELL;
`endif
  state_t state, nxt_state;
  logic [SEL_W-1:0] base, nxt_base, nxt_a, seek_idx;
  logic [N-1:0] mask_r, nxt_mask;
  logic [DWELL_W-1:0] cnt, nxt_cnt;
  logic stop_l, seek_found, wrap_unused, last_ch, nxt_sample;
  next_en_ch #(.SEL_W(SEL_W)) u_next (
    .mask(ch_en),
    .base(base),
    .idx(seek_idx),
    .found(seek_found),
    .wrapped(wrap_unused)
  );
  always_comb begin
    nxt_state = state;
    nxt_base = base;
    nxt_a = a;
    nxt_cnt = cnt;
    nxt_mask = mask_r;
    case (state)
      IDLE:
        if (start && |ch_en) begin
          nxt_state = SEEK;
          nxt_base = '0;
        end
      SEEK: begin
        nxt_mask = ch_en;
        nxt_state = seek_found ? AFTER_SEEK : IDLE;
        nxt_a = seek_found ? seek_idx : a;
        nxt_cnt = (dwell == '0) ? '0 : dwell - 1'b1;
      end
      SETTLE: nxt_state = DWELL;
      DWELL:
        if (cnt == '0) begin
          nxt_base = a + 1'b1;
          nxt_state = (stop_l || stop) ? IDLE : SEEK;
        end else
          nxt_cnt = cnt - 1'b1;
    endcase
  end
  // outputs are registered from next-state so they line up with the cycle they describe
  assign last_ch = ((nxt_mask >> nxt_a) >> 1) == '0;
  assign nxt_sample = (nxt_state == DWELL) && (nxt_cnt == '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      base <= '0;
      a <= '0;
      cnt <= '0;
      mask_r <= '0;
      stop_l <= 1'b0;
      sel_valid <= 1'b0;
      sample <= 1'b0;
      frame_done <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nxt_state;
      base <= nxt_base;
      a <= nxt_a;
      cnt <= nxt_cnt;
      mask_r <= nxt_mask;
      stop_l <= (nxt_state != IDLE) && (stop_l || (stop && state != IDLE));
      sel_valid <= nxt_state == DWELL;
      sample <= nxt_sample;
      frame_done <= nxt_sample && last_ch;
      busy <= nxt_state != IDLE;
    end
  end
endmodule

// File: tb/tb_mux_scan_seq.sv
// tb_mux_scan_seq: scoreboard bench for mux_scan_seq; honours MUX_SCAN_SETTLE_EN when defined
module tb_mux_scan_seq;
`ifdef MUX_SCAN_SETTLE_EN
  localparam int SETTLE = 1;
`else
  localparam int SETTLE = 0;
`endif
  typedef struct {logic [2:0] ch; logic fd;} exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [7:0] ch_en = '0, dwell = '0;
  logic [2:0] a;
  logic sel_valid, sample, frame_done, busy;
  int checks = 0, errors = 0;
  exp_t q[$];
  bit mon_en = 0, have_run = 0, prev_sv = 0;
  int run = 0, gap = 0, exp_run = 1;
  logic [2:0] prev_a = '0;

  mux_scan_seq dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .ch_en(ch_en), .dwell(dwell),
    .a(a), .sel_valid(sel_valid), .sample(sample), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // scoreboard monitor: sample events pop expected channels; run and gap lengths checked on edges of sel_valid
  always @(negedge clk) if (mon_en) begin
    if (sample) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sample_unexpected a=%0d queue empty", a);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (a !== e.ch || frame_done !== e.fd || sel_valid !== 1'b1) begin
          errors++;
          $display("FAIL sample_ch got a=%0d fd=%0b sv=%0b want a=%0d fd=%0b sv=1", a, frame_done, sel_valid, e.ch, e.fd);
        end
      end
    end else begin
      checks++;
      if (frame_done !== 1'b0) begin
        errors++;
        $display("FAIL fd_without_sample got fd=%0b want 0", frame_done);
      end
    end
    if (sel_valid) begin
      if (prev_sv) begin
        checks++;
        if (a !== prev_a) begin
          errors++;
          $display("FAIL a_stable got a=%0d want %0d", a, prev_a);
        end
      end else if (have_run) begin
        checks++;
        if (gap !== 1 + SETTLE) begin
          errors++;
          $display("FAIL gap_len got %0d want %0d", gap, 1 + SETTLE);
        end
      end
      gap = 0;
      run++;
    end else begin
      if (prev_sv) begin
        checks++;
        if (run !== exp_run) begin
          errors++;
          $display("FAIL run_len got %0d want %0d", run, exp_run);
        end
        have_run = 1;
      end
      run = 0;
      gap++;
    end
    prev_sv = sel_valid;
    prev_a = a;
  end

  task automatic push_pass(input logic [7:0] m, input int n);
    int ch = 0, hi = 0;
    exp_t e;
    for (int k = 0; k < 8; k++) if (m[k]) hi = k;
    for (int k = 0; k < n; k++) begin
      while (!m[ch]) ch = (ch + 1) % 8;
      e.ch = 3'(ch);
      e.fd = (ch == hi);
      q.push_back(e);
      ch = (ch + 1) % 8;
    end
  endtask

  // drives a scan of n channels, stopping gracefully during the last one
  task automatic run_scan(input logic [7:0] m, input logic [7:0] dw, input int n, output int lat, output bit to);
    int cnt = 0;
    bit got = 0;
    ch_en = m;
    dwell = dw;
    exp_run = (dw == 0) ? 1 : int'(dw);
    push_pass(m, n);
    have_run = 0; prev_sv = 0; run = 0; gap = 0;
    mon_en = 1;
    to = 0;
    lat = 0;
    start = 1;
    for (int c = 0; c < 2000 && cnt < n - 1; c++) begin
      @(negedge clk);
      start = 0;
      if (!got) lat++;
      if (sel_valid) got = 1;
      if (sample) cnt++;
    end
    if (cnt < n - 1) to = 1;
    @(negedge clk);
    stop = 1;
    @(negedge clk);
    stop = 0;
    for (int c = 0; c < 200 && busy; c++) @(negedge clk);
    if (busy) to = 1;
    @(negedge clk);
    mon_en = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({a, sel_valid, sample, frame_done, busy} !== 7'd0) begin
        errors++;
        $display("FAIL reset_idle got a=%0d sv=%0b s=%0b fd=%0b busy=%0b want all 0", a, sel_valid, sample, frame_done, busy);
      end
    end
    start = 1;
    ch_en = '0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL start_empty_mask got busy=%0b want 0", busy);
      end
    end
    start = 0;
  endtask

  task automatic test_full_scan;
    int lat;
    bit to;
    run_scan(8'hFF, 8'd3, 9, lat, to);
    checks++;
    if (to) begin errors++; $display("FAIL full_timeout got timeout want progress"); end
    checks++;
    if (lat !== 2 + SETTLE) begin errors++; $display("FAIL full_latency got %0d want %0d", lat, 2 + SETTLE); end
    checks++;
    if (q.size() !== 0) begin errors++; $display("FAIL full_leftover got %0d want 0", q.size()); end
    checks++;
    if (a !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL full_end got a=%0d busy=%0b want a=0 busy=0", a, busy); end
    q.delete();
  endtask

  task automatic test_sparse_wrap;
    int lat;
    bit to;
    run_scan(8'b1000_0101, 8'd1, 5, lat, to);
    checks++;
    if (to || q.size() !== 0) begin errors++; $display("FAIL sparse_done got to=%0b left=%0d want 0 0", to, q.size()); end
    checks++;
    if (a !== 3'd2) begin errors++; $display("FAIL sparse_end got a=%0d want 2", a); end
    q.delete();
  endtask

  task automatic test_single_dwell0;
    int lat;
    bit to;
    run_scan(8'h10, 8'd0, 4, lat, to);
    checks++;
    if (to || q.size() !== 0) begin errors++; $display("FAIL single_done got to=%0b left=%0d want 0 0", to, q.size()); end
    checks++;
    if (a !== 3'd4) begin errors++; $display("FAIL single_end got a=%0d want 4", a); end
    q.delete();
  endtask

  task automatic test_stop;
    int dc = 0;
    ch_en = 8'h08;
    dwell = 8'd5;
    exp_run = 5;
    push_pass(8'h08, 1);
    have_run = 0; prev_sv = 0; run = 0; gap = 0;
    mon_en = 1;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 20 && !sel_valid; c++) @(negedge clk);
    dc = 1;
    @(negedge clk);
    dc++;
    stop = 1;
    @(negedge clk);
    dc++;
    stop = 0;
    for (int c = 0; c < 20 && !sample; c++) begin @(negedge clk); dc++; end
    checks++;
    if (dc !== 5 || sample !== 1'b1) begin errors++; $display("FAIL stop_sample_cycle got %0d s=%0b want 5 1", dc, sample); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || a !== 3'd3 || sel_valid !== 1'b0) begin
      errors++;
      $display("FAIL stop_idle got busy=%0b a=%0d sv=%0b want 0 3 0", busy, a, sel_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || q.size() !== 0) begin errors++; $display("FAIL stop_hold got busy=%0b left=%0d want 0 0", busy, q.size()); end
    mon_en = 0;
    q.delete();
  endtask

  task automatic test_mid_reset;
    ch_en = 8'h08;
    dwell = 8'd5;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 20 && !sel_valid; c++) @(negedge clk);
    checks++;
    if (sel_valid !== 1'b1 || a !== 3'd3) begin errors++; $display("FAIL mrst_pre got sv=%0b a=%0d want 1 3", sel_valid, a); end
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    checks++;
    if ({a, sel_valid, sample, frame_done, busy} !== 7'd0) begin
      errors++;
      $display("FAIL mrst_outputs got a=%0d sv=%0b s=%0b fd=%0b busy=%0b want all 0", a, sel_valid, sample, frame_done, busy);
    end
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mrst_idle got busy=%0b want 0", busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_scan();
    test_sparse_wrap();
    test_single_dwell0();
    test_stop();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
